// File: rtl/card_pkg.sv
// card_pkg: shared constants, types and decode helpers for the card dealer.
//   DECK_SIZE/RANKS/SUITS  - deck geometry
//   RANK_A..RANK_K         - rank codes (0 = ace, 12 = king)
//   state_e                - dealer FSM state encoding
//   card_t                 - decoded {suit, rank} pair
//   rank_points()          - blackjack points for a rank
//   idx_decode()           - card index (suit*13 + rank) to {suit, rank}
package card_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned RANKS     = 13;
    localparam int unsigned SUITS     = 4;

    localparam logic [3:0] RANK_A  = 4'd0;
    localparam logic [3:0] RANK_2  = 4'd1;
    localparam logic [3:0] RANK_3  = 4'd2;
    localparam logic [3:0] RANK_4  = 4'd3;
    localparam logic [3:0] RANK_5  = 4'd4;
    localparam logic [3:0] RANK_6  = 4'd5;
    localparam logic [3:0] RANK_7  = 4'd6;
    localparam logic [3:0] RANK_8  = 4'd7;
    localparam logic [3:0] RANK_9  = 4'd8;
    localparam logic [3:0] RANK_10 = 4'd9;
    localparam logic [3:0] RANK_J  = 4'd10;
    localparam logic [3:0] RANK_Q  = 4'd11;
    localparam logic [3:0] RANK_K  = 4'd12;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StProbe = 2'd1,
        StValid = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    // Ace counts 11, face cards 10, pips their face value (rank code + 1).
    function automatic logic [3:0] rank_points(input logic [3:0] rank);
        if (rank == RANK_A) begin
            return 4'd11;
        end else if (rank >= RANK_J) begin
            return 4'd10;
        end else begin
            return rank + 4'd1;
        end
    endfunction

    // Compare chain instead of a divider: idx is at most 51.
    function automatic card_t idx_decode(input logic [5:0] idx);
        card_t c;
        if (idx >= 6'd39) begin
            c.suit = 2'd3;
            c.rank = 4'(idx - 6'd39);
        end else if (idx >= 6'd26) begin
            c.suit = 2'd2;
            c.rank = 4'(idx - 6'd26);
        end else if (idx >= 6'd13) begin
            c.suit = 2'd1;
            c.rank = 4'(idx - 6'd13);
        end else begin
            c.suit = 2'd0;
            c.rank = idx[3:0];
        end
        return c;
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
//   SEED  - reset value; 0 would lock the register, so it is replaced by 1
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads SEED
//   q     - current LFSR state, advances every cycle out of reset
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // Right-shifting Galois form: feedback mask for taps 16, 14, 13, 11.
    localparam logic [15:0] Taps    = 16'hB400;

    logic [15:0] q_d, q_q;

    always_comb begin
        q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? Taps : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SeedEff;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement from a 52-card deck.
//   req         - draw request, honoured in idle when cards remain
//   shuffle     - return every card to the deck (idle only, beats req)
//   card_ready  - consumer accepts the presented card
//   card_valid  - card presented, held until accepted
//   card_rank/card_suit/card_points/is_ace - registered card fields
//   cards_left  - undealt cards, deck_empty when zero
//   busy        - a draw is in progress or a card is awaiting acceptance
module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       shuffle,
    input  logic       card_ready,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [3:0] card_points,
    output logic       is_ace,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    localparam logic [5:0] DeckSize = 6'(DECK_SIZE);
    localparam logic [5:0] LastIdx  = 6'(DECK_SIZE - 1);

    state_e      state_d, state_q;
    logic [51:0] used_d, used_q;
    logic [5:0]  idx_d, idx_q;
    logic [5:0]  left_d, left_q;
    logic [3:0]  rank_d, rank_q;
    logic [1:0]  suit_d, suit_q;
    logic [3:0]  points_d, points_q;
    logic        ace_d, ace_q;

    logic [15:0] lfsr_val;
    logic [5:0]  lfsr_idx;
    logic        unused_lfsr;
    card_t       probe_card;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_val)
    );

    // Only the low six bits pick the start slot; the rest just keep the LFSR long.
    assign unused_lfsr = ^lfsr_val[15:6];
    assign lfsr_idx    = (lfsr_val[5:0] >= DeckSize) ? lfsr_val[5:0] - DeckSize : lfsr_val[5:0];
    assign probe_card  = idx_decode(idx_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q   <= '0;
            idx_q    <= '0;
            left_q   <= DeckSize;
            rank_q   <= '0;
            suit_q   <= '0;
            points_q <= '0;
            ace_q    <= 1'b0;
        end else begin
            used_q   <= used_d;
            idx_q    <= idx_d;
            left_q   <= left_d;
            rank_q   <= rank_d;
            suit_q   <= suit_d;
            points_q <= points_d;
            ace_q    <= ace_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        used_d   = used_q;
        idx_d    = idx_q;
        left_d   = left_q;
        rank_d   = rank_q;
        suit_d   = suit_q;
        points_d = points_q;
        ace_d    = ace_q;

        unique case (state_q)
            StIdle: begin
                if (shuffle) begin
                    used_d = '0;
                    left_d = DeckSize;
                end else if (req && (left_q != 6'd0)) begin
                    idx_d   = lfsr_idx;
                    state_d = StProbe;
                end
            end
            StProbe: begin
                // Linear probe: a free slot always exists because left_q was non-zero.
                if (used_q[idx_q]) begin
                    idx_d = (idx_q == LastIdx) ? 6'd0 : idx_q + 6'd1;
                end else begin
                    used_d[idx_q] = 1'b1;
                    left_d        = left_q - 6'd1;
                    rank_d        = probe_card.rank;
                    suit_d        = probe_card.suit;
                    points_d      = rank_points(probe_card.rank);
                    ace_d         = (probe_card.rank == RANK_A);
                    state_d       = StValid;
                end
            end
            StValid: begin
                if (card_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        card_valid  = (state_q == StValid);
        busy        = (state_q != StIdle);
        deck_empty  = (left_q == 6'd0);
        cards_left  = left_q;
        card_rank   = rank_q;
        card_suit   = suit_q;
        card_points = points_q;
        is_ace      = ace_q;
    end

endmodule
